// File: rtl/wb_trace_buffer.sv
// Commit-trace FIFO behind the MEM/WB register: captures one normalised commit record per
// retiring instruction and drains it over valid/ready. Optional drop counter: WB_TRACE_DROP_CNT_EN.
module wb_trace_buffer #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          have_inst_i,
    input  logic [31:0]   pc_i,
    input  logic          rf_we_i,
    input  logic [4:0]    wR_i,
    input  logic [31:0]   wD_i,
    output logic          tr_valid_o,
    input  logic          tr_ready_i,
    output logic [31:0]   tr_pc_o,
    output logic          tr_we_o,
    output logic [4:0]    tr_wR_o,
    output logic [31:0]   tr_wD_o,
    output logic [AW:0]   level_o,
    output logic          overflow_o
`ifdef WB_TRACE_DROP_CNT_EN
    ,
    output logic [15:0]   drop_cnt_o
`endif
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("wb_trace_buffer: DEPTH must be a power of two and at least 2");
    end

    typedef struct packed {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
    } rec_t;

    localparam logic [AW:0]   FULL    = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    // x0 writes are architecturally zero, and non-writing commits carry no destination.
    function automatic rec_t normalise(input logic [31:0] pc, input logic we,
                                       input logic [4:0] wr, input logic [31:0] wd);
        rec_t r;
        r.pc = pc;
        r.we = we;
        r.wr = we ? wr : 5'd0;
        r.wd = (we && wr != 5'd0) ? wd : 32'd0;
        return r;
    endfunction

    rec_t            mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [AW:0]     count;
    logic            ovf;
    logic            pop;
    logic            push;
    logic            drop;
    rec_t            head;

    // A pop at the same edge frees the slot, so a full FIFO still accepts the commit.
    assign pop  = (count != '0) && tr_ready_i;
    assign push = have_inst_i && ((count != FULL) || pop);
    assign drop = have_inst_i && !push;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push) wptr <= wptr + PTR_ONE;
            if (pop)  rptr <= rptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (drop) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) mem[wptr] <= normalise(pc_i, rf_we_i, wR_i, wD_i);
    end

`ifdef WB_TRACE_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            drop_cnt_o <= 16'd0;
        else if (drop && drop_cnt_o != 16'hFFFF)
            drop_cnt_o <= drop_cnt_o + 16'd1;
    end
`endif

    // Outputs come only from registered state; the head slot is masked while empty.
    assign head       = mem[rptr];
    assign tr_valid_o = (count != '0);
    assign tr_pc_o    = tr_valid_o ? head.pc : 32'd0;
    assign tr_we_o    = tr_valid_o ? head.we : 1'b0;
    assign tr_wR_o    = tr_valid_o ? head.wr : 5'd0;
    assign tr_wD_o    = tr_valid_o ? head.wd : 32'd0;
    assign level_o    = count;
    assign overflow_o = ovf;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Bench for wb_trace_buffer: directed scenarios plus randomized traffic checked against a
// queue-based reference model. Drop counter checked when WB_TRACE_DROP_CNT_EN is defined.
module tb_wb_trace_buffer;

    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic          clk;
    logic          rst;
    logic          have_inst_i;
    logic [31:0]   pc_i;
    logic          rf_we_i;
    logic [4:0]    wR_i;
    logic [31:0]   wD_i;
    logic          tr_valid_o;
    logic          tr_ready_i;
    logic [31:0]   tr_pc_o;
    logic          tr_we_o;
    logic [4:0]    tr_wR_o;
    logic [31:0]   tr_wD_o;
    logic [AW:0]   level_o;
    logic          overflow_o;
`ifdef WB_TRACE_DROP_CNT_EN
    logic [15:0]   drop_cnt_o;
`endif

    wb_trace_buffer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .have_inst_i(have_inst_i),
        .pc_i       (pc_i),
        .rf_we_i    (rf_we_i),
        .wR_i       (wR_i),
        .wD_i       (wD_i),
        .tr_valid_o (tr_valid_o),
        .tr_ready_i (tr_ready_i),
        .tr_pc_o    (tr_pc_o),
        .tr_we_o    (tr_we_o),
        .tr_wR_o    (tr_wR_o),
        .tr_wD_o    (tr_wD_o),
        .level_o    (level_o),
        .overflow_o (overflow_o)
`ifdef WB_TRACE_DROP_CNT_EN
        ,
        .drop_cnt_o (drop_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
    } mrec_t;

    mrec_t q[$];
    bit    m_ovf;
    int    m_drops;
    int    n_cmp;
    int    n_mis;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        mrec_t h;
        h = '{pc: 32'd0, we: 1'b0, wr: 5'd0, wd: 32'd0};
        if (q.size() != 0) h = q[0];
        chk("valid", 64'(tr_valid_o), 64'(q.size() != 0));
        chk("pc",    64'(tr_pc_o),    64'(h.pc));
        chk("we",    64'(tr_we_o),    64'(h.we));
        chk("wR",    64'(tr_wR_o),    64'(h.wr));
        chk("wD",    64'(tr_wD_o),    64'(h.wd));
        chk("level", 64'(level_o),    64'(q.size()));
        chk("ovf",   64'(overflow_o), 64'(m_ovf));
`ifdef WB_TRACE_DROP_CNT_EN
        chk("drops", 64'(drop_cnt_o), 64'(m_drops));
`endif
    endtask

    // One clock: the model applies this edge's rules, then outputs are compared 1ns later.
    task automatic step();
        bit    do_pop;
        mrec_t r;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            do_pop = (q.size() != 0) && tr_ready_i;
            if (do_pop) void'(q.pop_front());
            if (have_inst_i) begin
                if (q.size() < DEPTH) begin
                    r.pc = pc_i;
                    r.we = rf_we_i;
                    r.wr = rf_we_i ? wR_i : 5'd0;
                    r.wd = (rf_we_i && wR_i != 5'd0) ? wD_i : 32'd0;
                    q.push_back(r);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drops < 65535) m_drops++;
                end
            end
        end
        #1;
        compare_all();
    endtask

    task automatic commit(input logic h, input logic [31:0] pc, input logic we,
                          input logic [4:0] wr, input logic [31:0] wd);
        have_inst_i = h;
        pc_i        = pc;
        rf_we_i     = we;
        wR_i        = wr;
        wD_i        = wd;
    endtask

    initial begin
        int p_have;
        int p_ready;
        n_cmp   = 0;
        n_mis   = 0;
        m_ovf   = 1'b0;
        m_drops = 0;
        rst        = 1'b1;
        tr_ready_i = 1'b0;
        commit(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("reset_valid", 64'(tr_valid_o), 64'd0);
        chk("reset_level", 64'(level_o), 64'd0);
        chk("reset_ovf",   64'(overflow_o), 64'd0);
        chk("reset_pc",    64'(tr_pc_o), 64'd0);

        // Single commit held for three cycles, then accepted.
        commit(1'b1, 32'h10, 1'b1, 5'd5, 32'hDEADBEEF);
        step();
        commit(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("single_valid", 64'(tr_valid_o), 64'd1);
        chk("single_pc",    64'(tr_pc_o), 64'h10);
        chk("single_wD",    64'(tr_wD_o), 64'hDEADBEEF);
        chk("single_level", 64'(level_o), 64'd1);
        repeat (3) step();
        chk("held_wR", 64'(tr_wR_o), 64'd5);
        tr_ready_i = 1'b1;
        step();
        tr_ready_i = 1'b0;
        chk("popped_valid", 64'(tr_valid_o), 64'd0);
        chk("popped_level", 64'(level_o), 64'd0);

        // Normalisation of non-writing and x0-writing commits.
        commit(1'b1, 32'h20, 1'b0, 5'd7, 32'h1234);
        step();
        chk("nowe_wR", 64'(tr_wR_o), 64'd0);
        chk("nowe_wD", 64'(tr_wD_o), 64'd0);
        tr_ready_i = 1'b1;
        commit(1'b1, 32'h24, 1'b1, 5'd0, 32'h55);
        step();
        chk("x0_we", 64'(tr_we_o), 64'd1);
        chk("x0_wD", 64'(tr_wD_o), 64'd0);
        commit(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
        step();
        tr_ready_i = 1'b0;

        // Overfill by two, then drain in order.
        for (int i = 0; i < 10; i++) begin
            commit(1'b1, 32'(4 * i), 1'b1, 5'(i + 1), 32'(i * 32'h111));
            step();
        end
        commit(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("full_level", 64'(level_o), 64'd8);
        chk("full_ovf",   64'(overflow_o), 64'd1);
`ifdef WB_TRACE_DROP_CNT_EN
        chk("full_drops", 64'(drop_cnt_o), 64'd2);
`endif
        tr_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_pc", 64'(tr_pc_o), 64'(4 * i));
            step();
        end
        tr_ready_i = 1'b0;
        chk("drained_level", 64'(level_o), 64'd0);

        // Full FIFO with simultaneous push and pop across the pointer wrap.
        for (int i = 0; i < 8; i++) begin
            commit(1'b1, 32'h100 + 32'(4 * i), 1'b1, 5'd3, 32'(i));
            step();
        end
        tr_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            commit(1'b1, 32'h200 + 32'(4 * i), 1'b1, 5'd4, 32'(i));
            step();
            chk("pp_level", 64'(level_o), 64'd8);
        end
        commit(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
`ifdef WB_TRACE_DROP_CNT_EN
        chk("pp_drops", 64'(drop_cnt_o), 64'd2);
`endif
        for (int i = 0; i < 8; i++) begin
            chk("wrap_pc", 64'(tr_pc_o),
                64'(i < 4 ? 32'h110 + 32'(4 * i) : 32'h200 + 32'(4 * (i - 4))));
            step();
        end
        tr_ready_i = 1'b0;

        // Reset beats a pending handshake.
        for (int i = 0; i < 5; i++) begin
            commit(1'b1, 32'h300 + 32'(4 * i), 1'b1, 5'd9, 32'(i));
            step();
        end
        commit(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
        tr_ready_i = 1'b1;
        rst        = 1'b1;
        step();
        rst        = 1'b0;
        tr_ready_i = 1'b0;
        chk("rst_valid", 64'(tr_valid_o), 64'd0);
        chk("rst_level", 64'(level_o), 64'd0);
        chk("rst_ovf",   64'(overflow_o), 64'd0);

        // Randomized traffic with varying pressure and occasional reset.
        p_have  = 50;
        p_ready = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                p_have  = $urandom_range(10, 95);
                p_ready = $urandom_range(5, 95);
            end
            rst        = ($urandom_range(0, 299) == 0);
            tr_ready_i = ($urandom_range(0, 99) < p_ready);
            commit($urandom_range(0, 99) < p_have, $urandom, 1'($urandom),
                   5'($urandom), $urandom);
            step();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/wb_trace_buffer.md
# wb_trace_buffer

Commit-trace consumer on the far side of the MEM/WB pipeline register. Each cycle the register's outputs flag a retiring instruction (`have_inst`, `pc`, `rf_we`, `wR`, `wD`), the block captures one commit record into a small FIFO. It drains records to the debug/trace sink over a valid/ready handshake, decoupling core retirement from a slower trace consumer. It reports fill level and overflow.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, minimum 2.
- `AW`, `$clog2(DEPTH)`: pointer width; derived, not overridden.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `have_inst_i`  in  1  MEM/WB holds a retiring instruction this cycle.
- `pc_i`  in  32  PC of retiring instruction.
- `rf_we_i`  in  1  instruction writes the register file.
- `wR_i`  in  5  destination register index.
- `wD_i`  in  32  writeback data.
- `tr_valid_o`  out  1  head record available.
- `tr_ready_i`  in  1  sink accepts head record.
- `tr_pc_o`  out  32  head record PC.
- `tr_we_o`  out  1  head record write-enable.
- `tr_wR_o`  out  5  head record destination index.
- `tr_wD_o`  out  32  head record write data.
- `level_o`  out  AW+1  number of stored records, 0..DEPTH.
- `overflow_o`  out  1  sticky: at least one commit dropped.
- `drop_cnt_o`  out  16  dropped-commit count; present only with `WB_TRACE_DROP_CNT_EN`.

## Operation
- Record = {pc, we, wR, wD}, 70 bits, stored in `DEPTH`-entry RAM; write pointer, read pointer (AW bits, natural wrap at DEPTH), occupancy count (AW+1 bits).
- Push: `have_inst_i`=1 at rising edge and (count<DEPTH or pop in the same edge).
- Pop: `tr_valid_o`=1 and `tr_ready_i`=1 at rising edge.
- Record normalisation at push: if `rf_we_i`=0, stored wR and wD are 0. If `rf_we_i`=1 and `wR_i`=0, stored we=1, wR=0, wD=0 (x0 write is architecturally zero).
- Push and pop at the same edge: both occur, count unchanged. This holds when full: the pop frees a slot, and the new commit is accepted, not dropped.
- Drop: `have_inst_i`=1, count==DEPTH, and no pop at that edge. The record is discarded and `overflow_o` is set. Existing contents are untouched.
- `tr_valid_o` = (count!=0). Payload outputs = RAM[rptr] when valid, forced to 0 when not valid.
- Payload is stable while `tr_valid_o`=1 and `tr_ready_i`=0. A held record is never replaced or reordered.
- `tr_ready_i` while empty has no effect.
- `level_o` = count, registered.
- `overflow_o` is cleared only by `rst`.

## Timing
- Reset (at the rising edge with `rst`=1):
  - Pointers, count, `overflow_o` and `drop_cnt_o` are cleared.
  - `tr_valid_o`=0, all `tr_*` payload=0, `level_o`=0.
  - RAM contents are not reset.
- `rst` has priority over a push or pop at the same edge. Records in flight are discarded, and the handshake does not complete.
- Latency: a commit sampled at edge k appears on `tr_*` immediately after edge k, with `tr_valid_o`=1 in cycle k+1. There is no combinational in→out bypass.
- Throughput: 1 push and 1 pop per cycle sustained.
- `tr_valid_o`, payload and `level_o` depend only on registered state. `tr_ready_i` never combinationally affects outputs.

## Configuration
- `WB_TRACE_DROP_CNT_EN` defined:
  - A 16-bit `drop_cnt_o` increments by 1 on every drop event.
  - It saturates at 16'hFFFF.
  - It is cleared by `rst`.
- Not defined: the port `drop_cnt_o` and its counter are absent. Only sticky `overflow_o` reports drops.

## Test plan
- After reset, no stimulus → `tr_valid_o`=0, payload 0, `level_o`=0, `overflow_o`=0.
- Single commit pc=0x00000010, we=1, wR=5, wD=0xDEADBEEF with ready=0.
  - Cycle after the edge: valid=1 with that payload, `level_o`=1.
  - Payload is held for 3 cycles.
  - Ready=1 for one edge → valid=0, `level_o`=0.
- Commit we=0, wR=7, wD=0x1234 → `tr_wR_o`=0, `tr_wD_o`=0. Commit we=1, wR=0, wD=0x55 → `tr_we_o`=1, `tr_wD_o`=0.
- DEPTH=8, ready=0, 10 commits with pc=0x0,0x4,…,0x24:
  - `level_o`=8, `overflow_o`=1, `drop_cnt_o`=2 (macro on).
  - Draining yields pc 0x0..0x1C in order.
- Full FIFO with ready=1 and have_inst=1 together for 4 cycles:
  - `level_o` stays 8, and there are no new drops.
  - Output order is preserved across the pointer wrap.
- `rst` asserted with 5 records stored and ready=1 at the same edge → the next cycle shows valid=0, `level_o`=0, `overflow_o`=0, and no record is handed over.
